// File: rtl/mul_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_arb_pkg
// Description : Shared types and helpers for the mul_arb multiplier arbiter.
//               - state_e   : sequencer state (IDLE, RUN)
//               - OWN0/OWN1 : encoding of the requester that owns the
//                             multiplier
//               - cnt_width : width of a down-counter that must hold WIDTH
// Revision    : 1.0 - initial release
// ============================================================================
package mul_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic OWN0 = 1'b0;
  localparam logic OWN1 = 1'b1;

  // Bits needed to count from WIDTH down to 1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage : mul_arb_pkg
`default_nettype wire

// File: rtl/mul_arb_seq.sv
`default_nettype none
// ============================================================================
// Module      : mul_seq
// Description : Sequential unsigned shift-add multiplier.
//               A start pulse loads the operands. After that, one
//               partial-product step is taken on every clock.
//               prod_o presents the accumulator including the step applied in
//               the current cycle. The caller can therefore register the
//               finished product on the same edge that completes the last
//               step.
// Ports       : clk     in   system clock
//               rst     in   synchronous active-high reset
//               start_i in   load a_i/b_i and clear the accumulator
//               a_i     in   multiplicand (WIDTH)
//               b_i     in   multiplier   (WIDTH)
//               prod_o  out  running product (2*WIDTH)
// Revision    : 1.0 - initial release
// ============================================================================
module mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] prod_o
);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] acc_d;

  // The multiplier register shifts right, so bit 0 always holds the bit
  // belonging to the current step. The multiplicand shifts left to match
  // that bit's weight.
  assign partial = mplier_q[0] ? mcand_q : '0;
  assign acc_d   = acc_q + partial;
  assign prod_o  = acc_d;

  // After WIDTH steps the multiplier register is all zero. Extra steps taken
  // while the arbiter idles therefore leave the accumulator unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start_i) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

endmodule : mul_seq
`default_nettype wire

// File: rtl/mul_arb.sv
`default_nettype none
// ============================================================================
// Module      : mul_arb
// Description : Two-port arbiter and sequencer for one shared shift-add
//               multiplier.
//               In IDLE, a request is granted and its operands are loaded
//               into mul_seq. The block then spends WIDTH cycles in RUN and
//               returns the 2*WIDTH-bit product with a done pulse to the
//               owner.
//               Arbitration is round-robin by default.
//               Defining MUL_ARB_FIXED_PRIO_EN selects fixed priority
//               (requester 0 wins) and removes the round-robin pointer.
// Ports       : clk            in   system clock
//               rst            in   synchronous active-high reset
//               req0_i/req1_i  in   request, held with operands until ack
//               a0_i,b0_i      in   requester 0 operands (WIDTH)
//               a1_i,b1_i      in   requester 1 operands (WIDTH)
//               ack0_o/ack1_o  out  one-cycle pulse, operands captured
//               done0_o/done1_o out one-cycle pulse, res_o valid for owner
//               res_o          out  product (2*WIDTH), held until next done
//               busy_o         out  high while a multiply is in progress
// Config      : MUL_ARB_FIXED_PRIO_EN (optional define)
// Revision    : 1.0 - initial release
// ============================================================================
module mul_arb
  import mul_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_i,
  input  logic [WIDTH-1:0]   a0_i,
  input  logic [WIDTH-1:0]   b0_i,
  input  logic               req1_i,
  input  logic [WIDTH-1:0]   a1_i,
  input  logic [WIDTH-1:0]   b1_i,
  output logic               ack0_o,
  output logic               ack1_o,
  output logic               done0_o,
  output logic               done1_o,
  output logic [2*WIDTH-1:0] res_o,
  output logic               busy_o
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 owner_q, owner_d;
  logic [2*WIDTH-1:0]   res_q, res_d;
  logic                 busy_q, busy_d;
  logic                 ack0_q, ack0_d;
  logic                 ack1_q, ack1_d;
  logic                 done0_q, done0_d;
  logic                 done1_q, done1_d;

  logic                 any_req;
  logic                 grant1;
  logic                 start;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [2*WIDTH-1:0]   prod;

  assign any_req = req0_i | req1_i;

  // --------------------------------------------------------------------------
  // Arbitration. grant1 is only meaningful while any_req is set. With no
  // request, the IDLE branch below ignores it.
  // --------------------------------------------------------------------------
`ifdef MUL_ARB_FIXED_PRIO_EN
  assign grant1 = req1_i & ~req0_i;
`else
  // last_q holds the requester served most recently. Reset marks requester 1
  // as served last, so requester 0 wins the first contested grant.
  logic last_q;

  assign grant1 = req1_i & (~req0_i | (last_q == OWN0));

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= OWN1;
    end else if ((state_q == IDLE) && any_req) begin
      last_q <= grant1 ? OWN1 : OWN0;
    end
  end
`endif

  assign op_a = grant1 ? a1_i : a0_i;
  assign op_b = grant1 ? b1_i : b0_i;

  // --------------------------------------------------------------------------
  // Shared multiplier
  // --------------------------------------------------------------------------
  mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul_seq (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .a_i     (op_a),
    .b_i     (op_b),
    .prod_o  (prod)
  );

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    res_d   = res_q;
    busy_d  = busy_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    start   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          start   = 1'b1;
          owner_d = grant1 ? OWN1 : OWN0;
          ack0_d  = ~grant1;
          ack1_d  = grant1;
          cnt_d   = CNT_INIT;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        cnt_d = cnt_q - CNT_LAST;
        // When cnt is 1, mul_seq is applying its final step, so prod
        // already holds the complete product.
        if (cnt_q == CNT_LAST) begin
          res_d   = prod;
          done0_d = (owner_q == OWN0);
          done1_d = (owner_q == OWN1);
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= OWN0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  assign ack0_o  = ack0_q;
  assign ack1_o  = ack1_q;
  assign done0_o = done0_q;
  assign done1_o = done1_q;
  assign res_o   = res_q;
  assign busy_o  = busy_q;

endmodule : mul_arb
`default_nettype wire

// File: tb/tb_mul_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_arb
// Description : Self-checking bench for mul_arb at WIDTH=8.
//               The reference model works from the interface rules.
//               - Expected products are plain a*b.
//               - The arbitration winner follows from who was served last.
//               - Timing uses fixed offsets from the sampling cycle:
//                 ack at +1, busy for WIDTH cycles, done at +WIDTH+1.
//               Honors MUL_ARB_FIXED_PRIO_EN for the expected winner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_arb;

  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1;
  logic [W-1:0]     a0, b0, a1, b1;
  logic             ack0, ack1, done0, done1, busy;
  logic [2*W-1:0]   res;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int m_last = 1;   // model: requester served most recently

  // Event monitor (sole writer of these variables)
  int             ack_cnt  [2];
  int             done_cnt [2];
  int             ack_at   [2];
  int             done_at  [2];
  logic [2*W-1:0] done_res [2];
  int             busy_cnt   = 0;
  int             excl_viol  = 0;

  mul_arb #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req0_i  (req0),
    .a0_i    (a0),
    .b0_i    (b0),
    .req1_i  (req1),
    .a1_i    (a1),
    .b1_i    (b1),
    .ack0_o  (ack0),
    .ack1_o  (ack1),
    .done0_o (done0),
    .done1_o (done1),
    .res_o   (res),
    .busy_o  (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 2; i++) begin
      ack_cnt[i] = 0; done_cnt[i] = 0; ack_at[i] = -1; done_at[i] = -1;
      done_res[i] = '0;
    end
  end

  always @(negedge clk) begin
    if (ack0 === 1'b1)  begin ack_cnt[0]++;  ack_at[0]  = cyc; end
    if (ack1 === 1'b1)  begin ack_cnt[1]++;  ack_at[1]  = cyc; end
    if (done0 === 1'b1) begin done_cnt[0]++; done_at[0] = cyc; done_res[0] = res; end
    if (done1 === 1'b1) begin done_cnt[1]++; done_at[1] = cyc; done_res[1] = res; end
    if (busy === 1'b1) busy_cnt++;
    if ((ack0 === 1'b1 && ack1 === 1'b1) || (done0 === 1'b1 && done1 === 1'b1))
      excl_viol++;
  end

  // ---------------- reference model ----------------
  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    return (2*W)'(a) * (2*W)'(b);
  endfunction

  function automatic int ref_winner(input logic r0, input logic r1);
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
`ifdef MUL_ARB_FIXED_PRIO_EN
    return 0;
`else
    return (m_last == 0) ? 1 : 0;
`endif
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int who, input logic r, input logic [W-1:0] a, input logic [W-1:0] b);
    if (who == 0) begin req0 = r; a0 = a; b0 = b; end
    else          begin req1 = r; a1 = a; b1 = b; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    step(3);
    checks++; if (ack0 !== 1'b0)  begin errors++; $display("FAIL reset_ack0: got %b want 0", ack0); end
    checks++; if (ack1 !== 1'b0)  begin errors++; $display("FAIL reset_ack1: got %b want 0", ack1); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done0: got %b want 0", done0); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done1: got %b want 0", done1); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (res !== '0)     begin errors++; $display("FAIL reset_res: got %0d want 0", res); end
    rst = 1'b0;
    m_last = 1;
    step(1);
  endtask

  task automatic test_single_op(input int who, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int oth = 1 - who;
    int ab  = ack_cnt[who];
    int ao  = ack_cnt[oth];
    int db  = done_cnt[who];
    int dob = done_cnt[oth];
    int bb  = busy_cnt;
    int c0  = cyc;
    logic [2*W-1:0] exp = ref_prod(a, b);
    drive(who, 1'b1, a, b);
    step(1);
    drive(who, 1'b0, a, b);
    step(W + 1);
    checks++; if (ack_cnt[who] - ab != 1) begin errors++; $display("FAIL %s ack_count: got %0d want 1", tag, ack_cnt[who] - ab); end
    checks++; if (ack_at[who] != c0 + 1) begin errors++; $display("FAIL %s ack_cycle: got %0d want %0d", tag, ack_at[who], c0 + 1); end
    checks++; if (ack_cnt[oth] - ao != 0) begin errors++; $display("FAIL %s other_ack: got %0d want 0", tag, ack_cnt[oth] - ao); end
    checks++; if (done_cnt[who] - db != 1) begin errors++; $display("FAIL %s done_count: got %0d want 1", tag, done_cnt[who] - db); end
    checks++; if (done_at[who] != c0 + W + 1) begin errors++; $display("FAIL %s done_cycle: got %0d want %0d", tag, done_at[who], c0 + W + 1); end
    checks++; if (done_res[who] !== exp) begin errors++; $display("FAIL %s res_at_done: got %0d want %0d", tag, done_res[who], exp); end
    checks++; if (done_cnt[oth] - dob != 0) begin errors++; $display("FAIL %s other_done: got %0d want 0", tag, done_cnt[oth] - dob); end
    checks++; if (busy_cnt - bb != W) begin errors++; $display("FAIL %s busy_cycles: got %0d want %0d", tag, busy_cnt - bb, W); end
    checks++; if (res !== exp) begin errors++; $display("FAIL %s res_hold: got %0d want %0d", tag, res, exp); end
    m_last = who;
  endtask

  task automatic test_reset_mid_run();
    int d0 = done_cnt[0];
    int d1 = done_cnt[1];
    drive(1, 1'b1, W'($urandom()), W'($urandom()));
    step(1);
    drive(1, 1'b0, a1, b1);
    step(3);
    rst = 1'b1;
    step(1);
    checks++; if ({ack0, ack1, done0, done1, busy} !== 5'b0) begin errors++; $display("FAIL midrst_flags: got %b want 00000", {ack0, ack1, done0, done1, busy}); end
    checks++; if (res !== '0) begin errors++; $display("FAIL midrst_res: got %0d want 0", res); end
    rst = 1'b0;
    m_last = 1;
    step(W + 3);
    checks++; if (done_cnt[0] + done_cnt[1] - d0 - d1 != 0) begin errors++; $display("FAIL midrst_no_done: got %0d want 0", done_cnt[0] + done_cnt[1] - d0 - d1); end
    test_single_op(1, 8'd2, 8'd3, "post_rst");
  endtask

  task automatic test_both_together();
    logic [W-1:0] oa [2];
    logic [W-1:0] ob [2];
    int w, l, c0;
    oa[0] = 8'd3; ob[0] = 8'd4; oa[1] = 8'd5; ob[1] = 8'd6;
    w = ref_winner(1'b1, 1'b1);
    l = 1 - w;
    drive(0, 1'b1, oa[0], ob[0]);
    drive(1, 1'b1, oa[1], ob[1]);
    c0 = cyc;
    step(1);
    drive(w, 1'b0, oa[w], ob[w]);
    m_last = w;
    step(W + 1);
    drive(l, 1'b0, oa[l], ob[l]);
    m_last = l;
    step(W + 1);
    checks++; if (ack_at[w] != c0 + 1) begin errors++; $display("FAIL both_first_ack r%0d: got %0d want %0d", w, ack_at[w], c0 + 1); end
    checks++; if (done_at[w] != c0 + W + 1) begin errors++; $display("FAIL both_first_done r%0d: got %0d want %0d", w, done_at[w], c0 + W + 1); end
    checks++; if (done_res[w] !== ref_prod(oa[w], ob[w])) begin errors++; $display("FAIL both_first_res: got %0d want %0d", done_res[w], ref_prod(oa[w], ob[w])); end
    checks++; if (ack_at[l] != c0 + W + 2) begin errors++; $display("FAIL both_second_ack r%0d: got %0d want %0d", l, ack_at[l], c0 + W + 2); end
    checks++; if (done_at[l] != c0 + 2*W + 2) begin errors++; $display("FAIL both_second_done r%0d: got %0d want %0d", l, done_at[l], c0 + 2*W + 2); end
    checks++; if (done_res[l] !== ref_prod(oa[l], ob[l])) begin errors++; $display("FAIL both_second_res: got %0d want %0d", done_res[l], ref_prod(oa[l], ob[l])); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] oa [2];
    logic [W-1:0] ob [2];
    logic [2*W-1:0] exp;
    logic [1:0] acks, dones;
    int w;
    for (int i = 0; i < 2; i++) begin
      oa[i] = W'($urandom()); ob[i] = W'($urandom());
      drive(i, 1'b1, oa[i], ob[i]);
    end
    for (int g = 0; g < 6; g++) begin
      w = ref_winner(1'b1, 1'b1);
      step(1);
      acks = {ack1, ack0};
      checks++; if (acks !== (2'b01 << w)) begin errors++; $display("FAIL b2b_grant%0d: got acks %b want %b", g, acks, 2'b01 << w); end
      exp = ref_prod(oa[w], ob[w]);
      m_last = w;
      oa[w] = W'($urandom()); ob[w] = W'($urandom());
      drive(w, 1'b1, oa[w], ob[w]);
      step(W);
      dones = {done1, done0};
      checks++; if (dones !== (2'b01 << w)) begin errors++; $display("FAIL b2b_done%0d: got dones %b want %b", g, dones, 2'b01 << w); end
      checks++; if (res !== exp) begin errors++; $display("FAIL b2b_res%0d: got %0d want %0d", g, res, exp); end
    end
    drive(0, 1'b0, oa[0], ob[0]);
    drive(1, 1'b0, oa[1], ob[1]);
    step(2);
  endtask

  task automatic test_pulse_while_busy();
    int a0b = ack_cnt[0];
    int d0b = done_cnt[0];
    int d1b = done_cnt[1];
    int c0  = cyc;
    logic [W-1:0] a = W'($urandom());
    logic [W-1:0] b = W'($urandom());
    logic [2*W-1:0] exp = ref_prod(a, b);
    drive(1, 1'b1, a, b);
    step(1);
    drive(1, 1'b0, a, b);
    step(2);
    drive(0, 1'b1, W'($urandom()), W'($urandom()));
    step(1);
    drive(0, 1'b0, a0, b0);
    step(W - 2);
    m_last = 1;
    checks++; if (ack_cnt[0] - a0b != 0) begin errors++; $display("FAIL pulse_no_ack0: got %0d want 0", ack_cnt[0] - a0b); end
    checks++; if (done_cnt[0] - d0b != 0) begin errors++; $display("FAIL pulse_no_done0: got %0d want 0", done_cnt[0] - d0b); end
    checks++; if (done_cnt[1] - d1b != 1) begin errors++; $display("FAIL pulse_done1_count: got %0d want 1", done_cnt[1] - d1b); end
    checks++; if (done_at[1] != c0 + W + 1) begin errors++; $display("FAIL pulse_done1_cycle: got %0d want %0d", done_at[1], c0 + W + 1); end
    checks++; if (done_res[1] !== exp) begin errors++; $display("FAIL pulse_res: got %0d want %0d", done_res[1], exp); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      test_single_op(int'($urandom_range(0, 1)), W'($urandom()), W'($urandom()), "random");
    end
  endtask

  initial begin
    test_reset();
    test_single_op(0, 8'd13, 8'd11, "basic_13x11");
    test_single_op(1, 8'd255, 8'd255, "max_sq");
    test_single_op(0, 8'd0, 8'd200, "zero");
    test_reset_mid_run();
    test_both_together();
    test_back_to_back();
    test_pulse_while_busy();
    test_random();
    checks++; if (excl_viol != 0) begin errors++; $display("FAIL exclusive_pulses: got %0d violations want 0", excl_viol); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mul_arb
`default_nettype wire
